// File: rtl/ps2_pkg.sv
// Shared PS/2 packet-stream definitions: FSM state encoding, framing constants and byte helpers.
// Both the packet transmitter and the packet receiver use these constants.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BYTE1 = 3'd1,
    BYTE2 = 3'd2,
    BYTE3 = 3'd3,
    GAP   = 3'd4
  } ps2_state_e;

  // Bit that marks the first byte of a packet; idle/gap bytes keep it clear.
  localparam int PS2_SYNC_BIT  = 3;
  localparam int PS2_PKT_BYTES = 3;

  // idx 0 selects byte1 (the MSB byte of the 24-bit packet).
  function automatic logic [7:0] ps2_pkt_byte(input logic [23:0] pkt, input int idx);
    return pkt[8*(PS2_PKT_BYTES-1-idx) +: 8];
  endfunction

  function automatic logic [7:0] ps2_force_sync(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    r[PS2_SYNC_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/ps2_packet_tx.sv
// Serializes 24-bit PS/2 mouse packets into a framed byte stream; byte1 is presented one cycle after accept.
// Output stalls hold byte and state; in_ready drops while a packet or gap is in flight. Option: PS2TX_FRAME_CHECK_EN.
module ps2_packet_tx
  import ps2_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic [7:0]  IDLE_BYTE  = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] in_packet,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done,
  output logic        busy
`ifdef PS2TX_FRAME_CHECK_EN
  ,
  output logic        frame_err
`endif
);

  localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  if (IDLE_BYTE[PS2_SYNC_BIT]) begin : g_bad_idle_byte
    $error("ps2_packet_tx: IDLE_BYTE must keep the sync bit clear");
  end
  if (GAP_CYCLES > 15) begin : g_bad_gap_cycles
    $error("ps2_packet_tx: GAP_CYCLES must be in 0..15");
  end

  ps2_state_e  state_q, state_d;
  logic [23:0] pkt_q, pkt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        done_q, done_d;
  logic        accept;
  logic        pkt_bad;
  logic        start;
  logic [7:0]  byte1;

`ifdef PS2TX_FRAME_CHECK_EN
  logic frame_err_q, frame_err_d;

  // Unframed packets are consumed but dropped, so byte1 is sent unmodified.
  assign pkt_bad     = ~in_packet[16 + PS2_SYNC_BIT];
  assign byte1       = ps2_pkt_byte(pkt_q, 0);
  assign frame_err_d = accept && pkt_bad;
  assign frame_err   = frame_err_q;
`else
  assign pkt_bad = 1'b0;
  assign byte1   = ps2_force_sync(ps2_pkt_byte(pkt_q, 0));
`endif

  assign accept = in_valid && in_ready;
  assign start  = accept && !pkt_bad;
  assign done   = done_q;

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    out_valid = 1'b0;
    out_byte  = IDLE_BYTE;
    busy      = (state_q != IDLE);
    // The BYTE3 term lets the next packet start with no bubble when no gap is configured.
    in_ready  = (state_q == IDLE) ||
                ((state_q == BYTE3) && out_ready && (GAP_CYCLES == 0));

    if (accept) begin
      pkt_d = in_packet;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BYTE1;
        end
      end
      BYTE1: begin
        out_valid = 1'b1;
        out_byte  = byte1;
        if (out_ready) begin
          state_d = BYTE2;
        end
      end
      BYTE2: begin
        out_valid = 1'b1;
        out_byte  = ps2_pkt_byte(pkt_q, 1);
        if (out_ready) begin
          state_d = BYTE3;
        end
      end
      BYTE3: begin
        out_valid = 1'b1;
        out_byte  = ps2_pkt_byte(pkt_q, 2);
        if (out_ready) begin
          done_d = 1'b1;
          if (GAP_CYCLES != 0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else if (start) begin
            state_d = BYTE1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pkt_q     <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
    end
  end

`ifdef PS2TX_FRAME_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end
`endif

endmodule
